board_manager: RTL

// - Owns the 15x15 Gobang position directly upstream of the win checker. Accepts
//   one move per valid/ready handshake, validates it, commits the stone to the

---
 rtl/board_manager_pkg.sv | 31 +++
 rtl/board_manager_cell_index.sv | 12 +
 rtl/board_manager.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/board_manager_pkg.sv
// Shared Gobang constants: board geometry, player/winner/reject codes, FSM encodings.
package board_manager_pkg;

   localparam int BOARD_N = 15;
   localparam int CELLS   = BOARD_N * BOARD_N;
   localparam int CNT_W   = 8;

   localparam logic BLACK = 1'b0;
   localparam logic WHITE = 1'b1;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_BLACK = 2'b01;
   localparam logic [1:0] WIN_WHITE = 2'b10;
   localparam logic [1:0] WIN_DRAW  = 2'b11;

   localparam logic [1:0] REJ_NONE = 2'b00;
   localparam logic [1:0] REJ_OFF  = 2'b01;
   localparam logic [1:0] REJ_OCC  = 2'b10;
   localparam logic [1:0] REJ_SIDE = 2'b11;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_VALIDATE = 2'd1;
   localparam logic [1:0] ST_EVAL     = 2'd2;

   typedef struct packed {
      logic [3:0] row;
      logic [3:0] col;
      logic       player;
   } move_t;

endpackage

// File: rtl/board_manager_cell_index.sv
// Maps (row, col) to the flat cell index row*BOARD_N+col used by every board vector.
module cell_index
   import board_manager_pkg::*;
(
   input  logic [3:0] i_row,
   input  logic [3:0] i_col,
   output logic [7:0] o_idx
);

   assign o_idx = 8'(i_row) * 8'(BOARD_N) + 8'(i_col);

endmodule

// File: rtl/board_manager.sv
// Gobang position owner: validates one move per handshake, commits it, hands it to
// the external win checker and settles the outcome (win, draw or turn pass).
module board_manager
   import board_manager_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             new_game,
   input  logic             mv_valid,
   output logic             mv_ready,
   input  logic [3:0]       mv_row,
   input  logic [3:0]       mv_col,
   input  logic             mv_player,
   output logic [3:0]       chk_row,
   output logic [3:0]       chk_col,
   output logic [CELLS-1:0] chk_ch,
   input  logic             win_check,
   output logic [CELLS-1:0] board_black,
   output logic [CELLS-1:0] board_white,
   output logic             turn,
   output logic             game_over,
   output logic [1:0]       winner,
   output logic [CNT_W-1:0] move_count,
   output logic             acc_pulse,
   output logic             rej_pulse,
   output logic [1:0]       rej_code
);

   logic [1:0]       r_state;
   move_t            r_mv;
   logic [CELLS-1:0] r_black, r_white;
   logic             r_turn, r_over, r_chk_pl, r_acc, r_rej;
   logic [1:0]       r_winner, r_rej_code;
   logic [CNT_W-1:0] r_count;
   logic [3:0]       r_chk_row, r_chk_col;

   logic [7:0]       w_raw_idx, w_idx;
   logic             w_off, w_occ, w_side;
   logic [1:0]       w_code;

   cell_index u_cell_index (
      .i_row (r_mv.row),
      .i_col (r_mv.col),
      .o_idx (w_raw_idx)
   );

   // Off-board coordinates can alias onto real cells, so the index is forced to
   // zero and occupancy masked until the range check has passed.
   assign w_off  = (r_mv.row > 4'(BOARD_N - 1)) || (r_mv.col > 4'(BOARD_N - 1));
   assign w_idx  = w_off ? 8'd0 : w_raw_idx;
   assign w_occ  = !w_off && (r_black[w_idx] || r_white[w_idx]);
   assign w_side = (r_mv.player != r_turn);

   always_comb begin
      w_code = REJ_NONE;
      if (w_off)       w_code = REJ_OFF;
      else if (w_occ)  w_code = REJ_OCC;
      else if (w_side) w_code = REJ_SIDE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_mv       <= '0;
         r_black    <= '0;
         r_white    <= '0;
         r_turn     <= BLACK;
         r_over     <= 1'b0;
         r_winner   <= WIN_NONE;
         r_count    <= '0;
         r_chk_row  <= '0;
         r_chk_col  <= '0;
         r_chk_pl   <= BLACK;
         r_acc      <= 1'b0;
         r_rej      <= 1'b0;
         r_rej_code <= REJ_NONE;
      end else begin
         r_acc <= 1'b0;
         r_rej <= 1'b0;
         if (new_game) begin
            r_state    <= ST_IDLE;
            r_mv       <= '0;
            r_black    <= '0;
            r_white    <= '0;
            r_turn     <= BLACK;
            r_over     <= 1'b0;
            r_winner   <= WIN_NONE;
            r_count    <= '0;
            r_chk_row  <= '0;
            r_chk_col  <= '0;
            r_chk_pl   <= BLACK;
            r_rej_code <= REJ_NONE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (mv_valid && mv_ready) begin
                     r_mv    <= '{row: mv_row, col: mv_col, player: mv_player};
                     r_state <= ST_VALIDATE;
                  end
               end
               ST_VALIDATE: begin
                  if (w_code != REJ_NONE) begin
                     r_rej      <= 1'b1;
                     r_rej_code <= w_code;
                     r_state    <= ST_IDLE;
                  end else begin
                     if (r_mv.player == WHITE) r_white[w_idx] <= 1'b1;
                     else                      r_black[w_idx] <= 1'b1;
                     r_chk_row <= r_mv.row;
                     r_chk_col <= r_mv.col;
                     r_chk_pl  <= r_mv.player;
                     r_count   <= r_count + 1'b1;
                     r_state   <= ST_EVAL;
                  end
               end
               ST_EVAL: begin
                  r_acc   <= 1'b1;
                  r_state <= ST_IDLE;
                  // A five on the last free cell is still a win, so test it first.
                  if (win_check) begin
                     r_over   <= 1'b1;
                     r_winner <= (r_mv.player == WHITE) ? WIN_WHITE : WIN_BLACK;
                  end else if (r_count == CNT_W'(CELLS)) begin
                     r_over   <= 1'b1;
                     r_winner <= WIN_DRAW;
                  end else begin
                     r_turn <= ~r_turn;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign mv_ready    = (r_state == ST_IDLE) && !r_over;
   assign chk_row     = r_chk_row;
   assign chk_col     = r_chk_col;
   assign chk_ch      = r_chk_pl ? r_white : r_black;
   assign board_black = r_black;
   assign board_white = r_white;
   assign turn        = r_turn;
   assign game_over   = r_over;
   assign winner      = r_winner;
   assign move_count  = r_count;
   assign acc_pulse   = r_acc;
   assign rej_pulse   = r_rej;
   assign rej_code    = r_rej_code;

endmodule
